// File: rtl/relaxed_pkg.sv
// Shared types and constants for the relaxed delay responder.
package relaxed_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        P1   = 2'b01,
        P2   = 2'b10,
        P12  = 2'b11
    } state_e;

    localparam logic LAT_1 = 1'b0;
    localparam logic LAT_2 = 1'b1;

endpackage

// File: rtl/evt_counter.sv
// Wrapping event counter with synchronous active-high clear.
module evt_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/relaxed_delay_responder.sv
// Acknowledges every request within one or two cycles; hold or a 2-cycle preference
// defers a 1-cycle ack, but an age-2 request always forces ack.
module relaxed_delay_responder
    import relaxed_pkg::*;
#(
    parameter int unsigned CNT_W   = 16,
    parameter logic        LAT_DEF = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic             hold,
    input  logic             lat_wr,
    input  logic             lat_in,
    output logic             ack,
    output state_e           state,
    output logic [CNT_W-1:0] req_cnt,
    output logic [CNT_W-1:0] ack_cnt,
    output logic [CNT_W-1:0] late_cnt
);

    logic p1_q;
    logic p2_q;
    logic lat_sel_q;
    logic req_en;
    logic late_en;

    // One ack serves every outstanding request; a same-cycle req only lands in p1.
    always_comb begin
        ack = ~rst & (p2_q | (p1_q & ~hold & (lat_sel_q == LAT_1)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p1_q      <= 1'b0;
            p2_q      <= 1'b0;
            lat_sel_q <= LAT_DEF;
        end else begin
            p1_q <= req;
            p2_q <= p1_q & ~ack;
            if (lat_wr) begin
                lat_sel_q <= lat_in;
            end
        end
    end

    assign state   = state_e'({p2_q, p1_q});
    assign req_en  = req & ~rst;
    assign late_en = ack & p2_q;

    evt_counter #(
        .CNT_W(CNT_W)
    ) u_req_cnt (
        .clk(clk),
        .rst(rst),
        .en (req_en),
        .cnt(req_cnt)
    );

    evt_counter #(
        .CNT_W(CNT_W)
    ) u_ack_cnt (
        .clk(clk),
        .rst(rst),
        .en (ack),
        .cnt(ack_cnt)
    );

    evt_counter #(
        .CNT_W(CNT_W)
    ) u_late_cnt (
        .clk(clk),
        .rst(rst),
        .en (late_en),
        .cnt(late_cnt)
    );

endmodule

// File: tb/tb_relaxed_delay_responder.sv
// Randomized bench: compares the responder against a request-age reference model.
module tb_relaxed_delay_responder;
    import relaxed_pkg::*;

    localparam int unsigned CNT_W   = 4;
    localparam logic        LAT_DEF = 1'b0;
    localparam int          MASK    = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req = 1'b0;
    logic             hold = 1'b0;
    logic             lat_wr = 1'b0;
    logic             lat_in = 1'b0;
    logic             ack;
    state_e           state;
    logic [CNT_W-1:0] req_cnt;
    logic [CNT_W-1:0] ack_cnt;
    logic [CNT_W-1:0] late_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: cycle stamps of unserved requests, plus the DUT-observed obligations.
    int   pend[$];
    int   owed[$];
    logic lat_m = LAT_DEF;
    int   rc = 0;
    int   ac = 0;
    int   lc = 0;
    int   cyc = 0;

    relaxed_delay_responder #(
        .CNT_W  (CNT_W),
        .LAT_DEF(LAT_DEF)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .hold    (hold),
        .lat_wr  (lat_wr),
        .lat_in  (lat_in),
        .ack     (ack),
        .state   (state),
        .req_cnt (req_cnt),
        .ack_cnt (ack_cnt),
        .late_cnt(late_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        pend.delete();
        owed.delete();
        lat_m = LAT_DEF;
        rc = 0;
        ac = 0;
        lc = 0;
    endtask

    task automatic step(input logic r, input logic q, input logic h, input logic lw,
                        input logic li);
        logic has1;
        logic has2;
        logic e_ack;
        int   keep[$];
        @(posedge clk);
        #1;
        rst = r; req = q; hold = h; lat_wr = lw; lat_in = li;
        #4;
        has1 = 1'b0;
        has2 = 1'b0;
        foreach (pend[i]) begin
            if (cyc - pend[i] == 1) has1 = 1'b1;
            if (cyc - pend[i] == 2) has2 = 1'b1;
        end
        e_ack = !r && (has2 || (has1 && !h && lat_m == LAT_1));
        check_eq("ack", 32'(ack), 32'(e_ack));
        check_eq("state", 32'(state), 32'({has2, has1}));
        check_eq("req_cnt", 32'(req_cnt), rc);
        check_eq("ack_cnt", 32'(ack_cnt), ac);
        check_eq("late_cnt", 32'(late_cnt), lc);

        // Independent deadline watch on the DUT's own ack.
        if (r) begin
            owed.delete();
        end else if (ack === 1'b1) begin
            foreach (owed[i]) check_eq("ack_age_ok", 32'((cyc - owed[i]) inside {1, 2}), 1);
            owed.delete();
        end else begin
            foreach (owed[i]) begin
                if (cyc - owed[i] >= 2) check_eq("deadline_age", cyc - owed[i], 1);
                else keep.push_back(owed[i]);
            end
            owed = keep;
        end
        if (q && !r) owed.push_back(cyc);

        if (r) begin
            model_reset();
        end else begin
            if (e_ack) begin
                ac = (ac + 1) & MASK;
                if (has2) lc = (lc + 1) & MASK;
                pend.delete();
            end
            if (q) begin
                pend.push_back(cyc);
                rc = (rc + 1) & MASK;
            end
            if (lw) lat_m = li;
        end
        cyc++;
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        model_reset();

        // Reset state, then single req with immediate ack.
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        check_eq("single_ack", 32'(ack), 1);
        step(0, 0, 0, 0, 0);

        // Hold defers to age 2.
        step(0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        check_eq("hold_forced_ack", 32'(ack), 1);
        step(0, 0, 0, 0, 0);

        // Continuous req under hold: P1/P12 alternation.
        for (int i = 0; i < 4; i++) step(0, 1, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);

        // 2-cycle preference, then back to 1-cycle.
        step(0, 0, 0, 1, 1);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        check_eq("lat2_no_early", 32'(ack), 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        check_eq("lat1_ack", 32'(ack), 1);

        // Mid-operation reset discards the pending request; req during rst ignored.
        step(0, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        check_eq("rst_state", 32'(state), 32'(IDLE));
        step(0, 0, 0, 0, 0);

        // Counter wrap: 16 isolated reqs from reset.
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) begin
            step(0, 1, 0, 0, 0);
            step(0, 0, 0, 0, 0);
        end
        step(0, 0, 0, 0, 0);
        check_eq("wrap_req_cnt", 32'(req_cnt), 0);
        check_eq("wrap_ack_cnt", 32'(ack_cnt), 0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(63) == 0), $urandom_range(1), $urandom_range(1),
                 ($urandom_range(7) == 0), $urandom_range(1));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/relaxed_delay_responder.md
RELAXED_DELAY_RESPONDER -- requirements
Module: relaxed_delay_responder

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of all event counters.
REQ-002 SHALL have parameter LAT_DEF, default 0, reset value of the latency-preference register (0 = 1-cycle, 1 = 2-cycle).
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req  input  1  request pulse; each high cycle is one request.
REQ-006 hold  input  1  responder-side stall; defers a 1-cycle ack to 2 cycles, never beyond.
REQ-007 lat_wr  input  1  load lat_sel from lat_in this cycle.
REQ-008 lat_in  input  1  new latency preference.
REQ-009 ack  output  1  acknowledge; serves every pending request of age 1 or 2.
REQ-010 state  output  2  current pending state encoding (package enum).
REQ-011 req_cnt  output  CNT_W  requests seen since reset, wrapping.
REQ-012 ack_cnt  output  CNT_W  ack cycles since reset, wrapping.
REQ-013 late_cnt  output  CNT_W  acks issued at age 2 that served an age-2 request, wrapping.

Function
REQ-014 SHALL guarantee, for every cycle with req high at t, ack high in at least one of t+1 and t+2, for any hold/lat_sel sequence.
REQ-015 SHALL hold two flops: p1 (request at t-1 unserved), p2 (request at t-2 unserved); state = {p2,p1}: IDLE=00, P1=01, P2=10, P12=11.
REQ-016 ack SHALL be combinational from registered state: ack = p2 | (p1 & ~hold & ~lat_sel); ack SHALL be 0 while rst high.
REQ-017 Next state: p1' = req; p2' = p1 & ~ack.
REQ-018 An ack SHALL clear both p1 and p2 (one ack serves all outstanding requests).
REQ-019 A req in the same cycle as ack SHALL NOT be served by that ack; it sets p1'.
REQ-020 P12 (back-to-back reqs, first deferred) SHALL force ack regardless of hold; both cleared next cycle.
REQ-021 lat_sel SHALL update on the posedge where lat_wr is high; new value affects ack from the following cycle only.
REQ-022 req_cnt +1 per req cycle; ack_cnt +1 per ack cycle; late_cnt +1 per ack cycle with p2 high; all wrap modulo 2^CNT_W, no saturation.
REQ-023 hold high in IDLE or P2 SHALL have no effect on ack.

Reset
REQ-024 On rst: p1=p2=0 (state IDLE), lat_sel=LAT_DEF, all counters 0, ack 0.
REQ-025 rst mid-operation SHALL discard pending requests; no ack owed for requests at or before the reset cycle.
REQ-026 req sampled while rst high SHALL be ignored (not counted, not pending).

Structure
REQ-027 Package relaxed_pkg SHALL hold the 2-bit state enum (IDLE,P1,P2,P12) and the LAT_1/LAT_2 constants.
REQ-028 One sub-module evt_counter (CNT_W-wide, rst/en, wrapping) SHALL be instantiated three times for req_cnt, ack_cnt, late_cnt.
REQ-029 Estimated RTL 120-250 lines including sub-module and package.

Verification
REQ-030 Formal property SHALL be proven under unconstrained req/hold/lat_wr/lat_in: disable iff(rst) req |-> ##[1:2] ack.
REQ-031 Single req at t=3, hold=0, lat_sel=0 -> ack high at t=4 only; req_cnt=1, ack_cnt=1, late_cnt=0.
REQ-032 req at t=3, hold=1 at t=4 -> ack low t=4, high t=5; late_cnt=1.
REQ-033 req high t=3..6 continuous, hold=1 always -> state P1,P12 alternating; ack at t=5 and t=7; req_cnt=4, ack_cnt=2, late_cnt=2.
REQ-034 lat_wr=1, lat_in=1 at t=2; req at t=3 -> ack at t=5; then lat_in=0 at t=6, req at t=7 -> ack at t=8.
REQ-035 req at t=3, rst at t=4 -> no ack t=4..6, counters 0, state IDLE at t=5; counter wrap: CNT_W=4, 16 isolated reqs -> req_cnt returns to 0.
